// File: rtl/bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_serial
// Brief    : Serial double-dabble binary-to-BCD converter, one input bit per
//            clock, valid/ready input handshake and one-cycle result strobe.
// Revision : 1.0  initial release
// ============================================================================

module bin_to_bcd_serial #(
    parameter int BIN_WIDTH = 27,
    parameter int BCD_NUM   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_WIDTH-1:0] bin_value,
    output logic                 out_valid,
    output logic [3:0]           bcds [BCD_NUM-1:0],
    output logic                 overflow
);

    localparam int c_BCD_W = BCD_NUM * 4;
    localparam int c_REG_W = c_BCD_W + BIN_WIDTH;
    localparam int c_CNT_W = $clog2(BIN_WIDTH + 1);

    localparam logic [c_BCD_W-1:0] c_ALL_NINES = {BCD_NUM{4'h9}};
    localparam logic [c_BCD_W-1:0] c_ALL_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               r_state_q,     w_state_d;
    logic [c_REG_W-1:0]   r_work_q,      w_work_d;
    logic [c_CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic                 r_sticky_q,    w_sticky_d;
    logic [c_BCD_W-1:0]   r_bcds_q,      w_bcds_d;
    logic                 r_ovf_q,       w_ovf_d;
    logic                 r_out_valid_q, w_out_valid_d;

    logic [c_BCD_W-1:0]   w_adj_bcd;
    logic [c_REG_W-1:0]   w_cat;
    logic [c_REG_W-1:0]   w_shifted;
    logic                 w_sticky_next;

    // Add-3 correction on every digit, then one left shift of the whole register.
    // Digits stay within 0..9 after each step, so no inter-digit carry is needed.
    always_comb begin
        w_adj_bcd = r_work_q[c_REG_W-1:BIN_WIDTH];
        for (int i = 0; i < BCD_NUM; i++) begin
            if (w_adj_bcd[4*i +: 4] >= 4'd5) begin
                w_adj_bcd[4*i +: 4] = w_adj_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_cat         = {w_adj_bcd, r_work_q[BIN_WIDTH-1:0]};
        w_shifted     = {w_cat[c_REG_W-2:0], 1'b0};
        w_sticky_next = r_sticky_q | w_cat[c_REG_W-1];
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_work_d      = r_work_q;
        w_cnt_d       = r_cnt_q;
        w_sticky_d    = r_sticky_q;
        w_bcds_d      = r_bcds_q;
        w_ovf_d       = r_ovf_q;
        w_out_valid_d = 1'b0;

        if (r_state_q == ST_IDLE) begin
            if (in_valid) begin
                w_work_d   = {c_ALL_ZERO, bin_value};
                w_sticky_d = 1'b0;
                w_cnt_d    = c_CNT_LOAD;
                w_state_d  = ST_SHIFT;
            end
        end else begin
            w_work_d   = w_shifted;
            w_sticky_d = w_sticky_next;
            if (r_cnt_q == '0) begin
                w_state_d     = ST_IDLE;
                w_out_valid_d = 1'b1;
                w_ovf_d       = w_sticky_next;
                w_bcds_d      = w_sticky_next ? c_ALL_NINES
                                              : w_shifted[c_REG_W-1:BIN_WIDTH];
            end else begin
                w_cnt_d = r_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= ST_IDLE;
            r_work_q      <= '0;
            r_cnt_q       <= '0;
            r_sticky_q    <= 1'b0;
            r_bcds_q      <= '0;
            r_ovf_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_work_q      <= w_work_d;
            r_cnt_q       <= w_cnt_d;
            r_sticky_q    <= w_sticky_d;
            r_bcds_q      <= w_bcds_d;
            r_ovf_q       <= w_ovf_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = r_out_valid_q;
    assign overflow  = r_ovf_q;

    for (genvar g = 0; g < BCD_NUM; g++) begin : g_bcds
        assign bcds[g] = r_bcds_q[4*g +: 4];
    end

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_serial
// Brief    : Directed, table-driven self-checking bench for bin_to_bcd_serial.
// Revision : 1.0  initial release
// ============================================================================

module tb_bin_to_bcd_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] bin_value;
    logic        out_valid;
    logic [3:0]  bcds [7:0];
    logic        overflow;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_bin_value;
    logic        s_out_valid;
    logic [3:0]  s_bcds [1:0];
    logic        s_overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bin_to_bcd_serial #(.BIN_WIDTH(27), .BCD_NUM(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_value (bin_value),
        .out_valid (out_valid),
        .bcds      (bcds),
        .overflow  (overflow)
    );

    bin_to_bcd_serial #(.BIN_WIDTH(4), .BCD_NUM(2)) u_dut_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .bin_value (s_bin_value),
        .out_valid (s_out_valid),
        .bcds      (s_bcds),
        .overflow  (s_overflow)
    );

    logic [31:0] got_bcd;
    logic [7:0]  s_got_bcd;
    always_comb begin
        got_bcd = '0;
        for (int i = 0; i < 8; i++) got_bcd[4*i +: 4] = bcds[i];
        s_got_bcd = {s_bcds[1], s_bcds[0]};
    end

    typedef struct {
        string       name;
        logic [26:0] value;
        logic [31:0] bcd;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference conversion by repeated division, independent of double-dabble.
    function automatic logic [32:0] ref_bcd8(input int unsigned v);
        logic [31:0] r;
        int unsigned t;
        if (v >= 100000000) return {1'b1, 32'h9999_9999};
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {1'b0, r};
    endfunction

    // Called at a negedge with the DUT idle-or-becoming-idle.
    task automatic do_conv(input string name, input logic [26:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int idx;
        int busy;
        idx = 0;
        while (!in_ready && idx < 100) begin
            @(negedge clk);
            idx++;
        end
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        bin_value = v;
        @(negedge clk);
        in_valid  = 1'b0;
        bin_value = 27'h5A5A5A5;
        idx  = 0;
        busy = 0;
        while (!out_valid && idx < 200) begin
            if (!in_ready) busy++;
            @(negedge clk);
            idx++;
        end
        check({name, "_latency"}, 64'(idx), 64'd27);
        check({name, "_busy"}, 64'(busy), 64'd27);
        check({name, "_ready_at_strobe"}, 64'(in_ready), 64'd1);
        check({name, "_bcd"}, 64'(got_bcd), 64'(exp_bcd));
        check({name, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        check({name, "_strobe_len"}, 64'(out_valid), 64'd0);
        check({name, "_hold"}, 64'(got_bcd), 64'(exp_bcd));
    endtask

    task automatic do_conv_small(input int v);
        int idx;
        logic [7:0] exp_bcd;
        exp_bcd     = {4'(v / 10), 4'(v % 10)};
        s_in_valid  = 1'b1;
        s_bin_value = 4'(v);
        @(negedge clk);
        s_in_valid  = 1'b0;
        idx = 0;
        while (!s_out_valid && idx < 50) begin
            @(negedge clk);
            idx++;
        end
        check($sformatf("small_%0d_latency", v), 64'(idx), 64'd4);
        check($sformatf("small_%0d_bcd", v), 64'(s_got_bcd), 64'(exp_bcd));
        check($sformatf("small_%0d_ovf", v), 64'(s_overflow), 64'd0);
        @(negedge clk);
        check($sformatf("small_%0d_strobe_len", v), 64'(s_out_valid), 64'd0);
    endtask

    initial begin
        logic [26:0] q [$];
        logic [26:0] e;
        logic [32:0] m;
        int          strobes;
        int          last_strobe;
        int          early;

        vecs[0] = '{"zero",      27'd0,         32'h0000_0000, 1'b0};
        vecs[1] = '{"mid",       27'd12345678,  32'h1234_5678, 1'b0};
        vecs[2] = '{"v905",      27'd905,       32'h0000_0905, 1'b0};
        vecs[3] = '{"one",       27'd1,         32'h0000_0001, 1'b0};
        vecs[4] = '{"ten",       27'd10,        32'h0000_0010, 1'b0};
        vecs[5] = '{"v9999",     27'd9999,      32'h0000_9999, 1'b0};
        vecs[6] = '{"v5e7",      27'd50000000,  32'h5000_0000, 1'b0};
        vecs[7] = '{"max_fit",   27'd99999999,  32'h9999_9999, 1'b0};
        vecs[8] = '{"first_ovf", 27'd100000000, 32'h9999_9999, 1'b1};
        vecs[9] = '{"all_ones",  27'd134217727, 32'h9999_9999, 1'b1};

        reset       = 1'b1;
        in_valid    = 1'b0;
        bin_value   = '0;
        s_in_valid  = 1'b0;
        s_bin_value = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_bcds", 64'(got_bcd), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_conv(vecs[i].name, vecs[i].value, vecs[i].bcd, vecs[i].ovf);
        end

        // Back-to-back with in_valid held high and bin_value changing every cycle.
        strobes     = 0;
        last_strobe = -1;
        for (int c = 0; c < 130; c++) begin
            if (out_valid) begin
                strobes++;
                check("b2b_queue_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    m = ref_bcd8(32'(e));
                    check("b2b_bcd", 64'(got_bcd), 64'(m[31:0]));
                    check("b2b_ovf", 64'(overflow), 64'(m[32]));
                end
                if (last_strobe >= 0) check("b2b_spacing", 64'(c - last_strobe), 64'd28);
                last_strobe = c;
            end
            if (c < 90) begin
                in_valid  = 1'b1;
                bin_value = 27'(500000 + c * 12347);
                if (in_ready) q.push_back(bin_value);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_drained", 64'(q.size()), 64'd0);
        check("b2b_strobes", 64'(strobes), 64'd4);

        // Reset mid-conversion, with in_valid asserted during reset.
        in_valid  = 1'b1;
        bin_value = 27'd4321;
        @(negedge clk);
        in_valid  = 1'b0;
        early = 0;
        repeat (10) begin
            if (out_valid) early++;
            @(negedge clk);
        end
        reset     = 1'b1;
        in_valid  = 1'b1;
        bin_value = 27'd55;
        @(negedge clk);
        check("midrst_bcds", 64'(got_bcd), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_wins_in_ready", 64'(in_ready), 64'd1);
        repeat (30) begin
            if (out_valid) early++;
            @(negedge clk);
        end
        check("midrst_no_strobe", 64'(early), 64'd0);
        check("midrst_bcds_held", 64'(got_bcd), 64'd0);
        do_conv("after_rst", 27'd7, 32'h0000_0007, 1'b0);

        // Narrow instance: exhaustive sweep.
        for (int v = 0; v < 16; v++) begin
            do_conv_small(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
